// File: rtl/act_ctrl_pkg.sv
// act_ctrl_pkg: shared types and default constants for the actuator decision block.
package act_ctrl_pkg;

    // Per-axis hysteresis state; LOW_ACT/HIGH_ACT map to HEAT/COOL or HUM/DEHUM.
    typedef enum logic [1:0] {
        AXIS_IDLE     = 2'd0,
        AXIS_LOW_ACT  = 2'd1,
        AXIS_HIGH_ACT = 2'd2
    } axis_state_e;

    localparam int ACT_DATA_W        = 8;
    localparam int ACT_HYST_DEF      = 2;
    localparam int ACT_MIN_DWELL_DEF = 16;

endpackage

// File: rtl/act_axis_fsm.sv
// act_axis_fsm: one hysteresis axis (IDLE / LOW_ACT / HIGH_ACT) with threshold
// comparators and an optional minimum-dwell counter.
// Optional feature: define ACT_MIN_DWELL_EN to build the dwell counter; without it
// an active state may be left on the first sample after entry.
module act_axis_fsm
    import act_ctrl_pkg::*;
#(
    parameter int DATA_W     = ACT_DATA_W,
    parameter bit SIGNED_CMP = 1'b0,
    parameter int HYST       = ACT_HYST_DEF,
    parameter int MIN_DWELL  = ACT_MIN_DWELL_DEF
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              ctrl_en,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] low,
    input  logic [DATA_W-1:0] high,
    output logic              cfg_bad,
    output logic              low_act,
    output logic              high_act
);

    // Thresholds +/- HYST are formed one bit wider so the exit levels never wrap.
    logic lt_low;
    logic gt_high;
    logic exit_low;
    logic exit_high;
    logic dwell_done;

    generate
        if (SIGNED_CMP) begin : g_signed
            localparam logic signed [DATA_W:0] HYST_S = (DATA_W+1)'(HYST);
            logic signed [DATA_W:0] d_s;
            logic signed [DATA_W:0] lo_s;
            logic signed [DATA_W:0] hi_s;
            assign d_s       = {data[DATA_W-1], data};
            assign lo_s      = {low[DATA_W-1], low};
            assign hi_s      = {high[DATA_W-1], high};
            assign lt_low    = (d_s < lo_s);
            assign gt_high   = (d_s > hi_s);
            assign exit_low  = (d_s >= (lo_s + HYST_S));
            assign exit_high = (d_s <= (hi_s - HYST_S));
            assign cfg_bad   = (lo_s >= hi_s);
        end else begin : g_unsigned
            localparam logic [DATA_W:0] HYST_U = (DATA_W+1)'(HYST);
            logic [DATA_W:0] d_u;
            logic [DATA_W:0] lo_u;
            logic [DATA_W:0] hi_u;
            assign d_u       = {1'b0, data};
            assign lo_u      = {1'b0, low};
            assign hi_u      = {1'b0, high};
            assign lt_low    = (d_u < lo_u);
            assign gt_high   = (d_u > hi_u);
            assign exit_low  = (d_u >= (lo_u + HYST_U));
            // data <= high - HYST rewritten as data + HYST <= high: no unsigned underflow
            assign exit_high = ((d_u + HYST_U) <= hi_u);
            assign cfg_bad   = (lo_u >= hi_u);
        end
    endgenerate

    axis_state_e state_p1;
    axis_state_e state_nxt;

`ifdef ACT_MIN_DWELL_EN
    localparam int DW_W = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;
    logic [DW_W-1:0] dwell_p1;

    assign dwell_done = (dwell_p1 == '0);

    // Dwell counter: reload on entry to an active state, then count down to zero.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            dwell_p1 <= '0;
        end else if ((state_p1 == AXIS_IDLE) && (state_nxt != AXIS_IDLE)) begin
            dwell_p1 <= DW_W'(MIN_DWELL - 1);
        end else if (dwell_p1 != '0) begin
            dwell_p1 <= dwell_p1 - 1'b1;
        end
    end
`else
    // No dwell constraint; MIN_DWELL stays referenced so both builds share one parameter list.
    assign dwell_done = 1'b1 | (MIN_DWELL < 0);
`endif

    // Next state: disable and bad thresholds force IDLE; otherwise only a valid sample moves the axis.
    always_comb begin
        state_nxt = state_p1;
        if (!ctrl_en || cfg_bad) begin
            state_nxt = AXIS_IDLE;
        end else if (sample_valid) begin
            case (state_p1)
                AXIS_IDLE: begin
                    if (lt_low) begin
                        state_nxt = AXIS_LOW_ACT;
                    end else if (gt_high) begin
                        state_nxt = AXIS_HIGH_ACT;
                    end
                end
                AXIS_LOW_ACT: begin
                    if (exit_low && dwell_done) begin
                        state_nxt = AXIS_IDLE;
                    end
                end
                AXIS_HIGH_ACT: begin
                    if (exit_high && dwell_done) begin
                        state_nxt = AXIS_IDLE;
                    end
                end
                default: state_nxt = AXIS_IDLE;
            endcase
        end
    end

    // State register plus registered enables decoded from the next state.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_p1 <= AXIS_IDLE;
            low_act  <= 1'b0;
            high_act <= 1'b0;
        end else begin
            state_p1 <= state_nxt;
            low_act  <= (state_nxt == AXIS_LOW_ACT);
            high_act <= (state_nxt == AXIS_HIGH_ACT);
        end
    end

endmodule

// File: rtl/act_ctrl.sv
// act_ctrl: actuator decision block with independent temperature (signed) and
// humidity (unsigned) hysteresis axes plus a registered threshold-error flag.
// Optional feature: ACT_MIN_DWELL_EN enables per-axis minimum dwell in active states.
module act_ctrl
    import act_ctrl_pkg::*;
#(
    parameter int HYST      = ACT_HYST_DEF,
    parameter int MIN_DWELL = ACT_MIN_DWELL_DEF
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  ctrl_en,
    input  logic                  sample_valid,
    input  logic [ACT_DATA_W-1:0] temp_data,
    input  logic [ACT_DATA_W-1:0] hum_data,
    input  logic [ACT_DATA_W-1:0] temp_low,
    input  logic [ACT_DATA_W-1:0] temp_high,
    input  logic [ACT_DATA_W-1:0] hum_low,
    input  logic [ACT_DATA_W-1:0] hum_high,
    output logic                  heater_en,
    output logic                  fan_en,
    output logic                  humidifier_en,
    output logic                  dehumidifier_en,
    output logic                  cfg_err
);

    logic temp_cfg_bad;
    logic hum_cfg_bad;

    act_axis_fsm #(
        .DATA_W     (ACT_DATA_W),
        .SIGNED_CMP (1'b1),
        .HYST       (HYST),
        .MIN_DWELL  (MIN_DWELL)
    ) u_temp_axis (
        .pclk         (pclk),
        .presetn      (presetn),
        .ctrl_en      (ctrl_en),
        .sample_valid (sample_valid),
        .data         (temp_data),
        .low          (temp_low),
        .high         (temp_high),
        .cfg_bad      (temp_cfg_bad),
        .low_act      (heater_en),
        .high_act     (fan_en)
    );

    act_axis_fsm #(
        .DATA_W     (ACT_DATA_W),
        .SIGNED_CMP (1'b0),
        .HYST       (HYST),
        .MIN_DWELL  (MIN_DWELL)
    ) u_hum_axis (
        .pclk         (pclk),
        .presetn      (presetn),
        .ctrl_en      (ctrl_en),
        .sample_valid (sample_valid),
        .data         (hum_data),
        .low          (hum_low),
        .high         (hum_high),
        .cfg_bad      (hum_cfg_bad),
        .low_act      (humidifier_en),
        .high_act     (dehumidifier_en)
    );

    // Threshold error flag, one cycle behind the threshold inputs.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= temp_cfg_bad | hum_cfg_bad;
        end
    end

endmodule

// File: tb/tb_act_ctrl.sv
// tb_act_ctrl: directed self-checking bench for act_ctrl (HYST=2, MIN_DWELL=16).
// Expectations that depend on the dwell feature follow ACT_MIN_DWELL_EN.
module tb_act_ctrl;

`ifdef ACT_MIN_DWELL_EN
    localparam logic DWELL_ON = 1'b1;
`else
    localparam logic DWELL_ON = 1'b0;
`endif

    logic       pclk = 1'b0;
    logic       presetn;
    logic       ctrl_en;
    logic       sample_valid;
    logic [7:0] temp_data;
    logic [7:0] hum_data;
    logic [7:0] temp_low;
    logic [7:0] temp_high;
    logic [7:0] hum_low;
    logic [7:0] hum_high;
    logic       heater_en;
    logic       fan_en;
    logic       humidifier_en;
    logic       dehumidifier_en;
    logic       cfg_err;

    int errors = 0;
    int checks = 0;

    always #5 pclk = ~pclk;

    act_ctrl #(
        .HYST      (2),
        .MIN_DWELL (16)
    ) dut (
        .pclk            (pclk),
        .presetn         (presetn),
        .ctrl_en         (ctrl_en),
        .sample_valid    (sample_valid),
        .temp_data       (temp_data),
        .hum_data        (hum_data),
        .temp_low        (temp_low),
        .temp_high       (temp_high),
        .hum_low         (hum_low),
        .hum_high        (hum_high),
        .heater_en       (heater_en),
        .fan_en          (fan_en),
        .humidifier_en   (humidifier_en),
        .dehumidifier_en (dehumidifier_en),
        .cfg_err         (cfg_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a falling edge: present one sample, captured at the next rising edge,
    // and return at the following falling edge where the result is visible.
    task automatic send(input int t, input int h);
        temp_data    = 8'(t);
        hum_data     = 8'(h);
        sample_valid = 1'b1;
        @(negedge pclk);
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic check_all_off(input string tag);
        check({tag, "_heater"}, heater_en, 0);
        check({tag, "_fan"}, fan_en, 0);
        check({tag, "_hum"}, humidifier_en, 0);
        check({tag, "_dehum"}, dehumidifier_en, 0);
    endtask

    initial begin
        presetn      = 1'b0;
        ctrl_en      = 1'b1;
        sample_valid = 1'b0;
        temp_data    = 8'd22;
        hum_data     = 8'd45;
        temp_low     = 8'd18;
        temp_high    = 8'd26;
        hum_low      = 8'd30;
        hum_high     = 8'd60;
        #1;
        check_all_off("reset");
        check("reset_cfg_err", cfg_err, 0);
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);

        // Heat cycle with hysteresis and dwell expiry
        send(15, 45);
        check("heat_enter", heater_en, 1);
        check("heat_enter_fan", fan_en, 0);
        send(19, 45);
        check("heat_in_band", heater_en, 1);
        idle(15);
        send(20, 45);
        check("heat_exit", heater_en, 0);

        // Cool entry, blocked early exit, later exit
        send(30, 45);
        check("cool_enter", fan_en, 1);
        idle(4);
        send(20, 45);
        check("dwell_block_fan", fan_en, DWELL_ON);
        idle(14);
        send(20, 45);
        check("cool_exit", fan_en, 0);

        // Humidity axis: DEHUM must pass through IDLE before HUM
        send(22, 70);
        check("dehum_enter", dehumidifier_en, 1);
        check("dehum_enter_hum", humidifier_en, 0);
        idle(16);
        send(22, 20);
        check("dehum_exit", dehumidifier_en, 0);
        check("no_direct_hum", humidifier_en, 0);
        send(22, 20);
        check("hum_enter", humidifier_en, 1);

        // Clear both axes via one disabled cycle
        ctrl_en = 1'b0;
        @(negedge pclk);
        ctrl_en = 1'b1;
        check_all_off("clear");

        // Temperature thresholds inverted: axis held idle, humidity still works
        temp_low  = 8'd30;
        temp_high = 8'd20;
        idle(1);
        check("cfg_err_temp", cfg_err, 1);
        send(-5, 70);
        check("cfg_heater", heater_en, 0);
        check("cfg_fan", fan_en, 0);
        check("cfg_hum_works", dehumidifier_en, 1);
        temp_low  = 8'd18;
        temp_high = 8'd26;
        hum_low   = 8'd60;
        hum_high  = 8'd30;
        idle(1);
        check("cfg_err_hum", cfg_err, 1);
        check("cfg_hum_forced_idle", dehumidifier_en, 0);
        hum_low  = 8'd30;
        hum_high = 8'd60;
        idle(1);
        check("cfg_err_clear", cfg_err, 0);

        // Disable in the same cycle as a sample, mid-dwell
        send(15, 70);
        check("pre_dis_heater", heater_en, 1);
        check("pre_dis_dehum", dehumidifier_en, 1);
        ctrl_en      = 1'b0;
        sample_valid = 1'b1;
        @(negedge pclk);
        sample_valid = 1'b0;
        check_all_off("disable");
        ctrl_en = 1'b1;
        send(22, 45);
        check("reenable_from_idle", heater_en, 0);
        send(15, 45);
        check("reenable_heat", heater_en, 1);

        // Asynchronous reset while heater is on
        #2;
        presetn = 1'b0;
        #1;
        check_all_off("async_rst");
        check("async_rst_cfg", cfg_err, 0);
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);

        // Signed threshold edge
        temp_low = 8'hF6;
        idle(1);
        check("signed_cfg_ok", cfg_err, 0);
        send(-10, 45);
        check("signed_at_low", heater_en, 0);
        send(-11, 45);
        check("signed_below_low", heater_en, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
